// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the core load/store path and the data memory.
// The core side uses the master modport and the memory controller uses the slave modport.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] din;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] dout;

  modport master (
    output req_valid, mem_read, mem_write, addr, din,
    input  req_ready, resp_valid, resp_err, dout
  );

  modport slave (
    input  req_valid, mem_read, mem_write, addr, din,
    output req_ready, resp_valid, resp_err, dout
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Multi-cycle word-addressed data memory with a fixed access latency.
// Illegal requests keep the normal timing and complete with an error response.
module data_memory_ctrl #(
  parameter int NUM_WORDS = 1024,
  parameter int LATENCY   = 3
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_ctrl_if.slave  bus
);
  localparam int AW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            rd_q, err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     dout_q;
  logic [31:0]     mem_q [NUM_WORDS];
  logic            accept, access, req_illegal;

  // Upper address bits are deliberately ignored so addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:AW+2];

  assign req_illegal = (bus.addr[1:0] != 2'b00) || (bus.mem_read == bus.mem_write);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rd_q    <= bus.mem_read;
        err_q   <= req_illegal;
        idx_q   <= bus.addr[AW+1:2];
        wdata_q <= bus.din;
      end
      if (access && !err_q && rd_q) dout_q <= mem_q[idx_q];
    end
  end

  // Whole array clears on reset so a load after reset always returns zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else if (access && !err_q && !rd_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_err   = (state_q == DONE) && err_q;
  assign bus.dout       = dout_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed scenarios followed by random traffic
// compared against a word-array reference model.
module tb_data_memory_ctrl;
  localparam int NW  = 1024;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_memory_ctrl_if bus();

  data_memory_ctrl #(.NUM_WORDS(NW), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [NW];
  logic [31:0] ref_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input bit rd, input bit wr, input logic [31:0] a);
    return (a % 4 == 0) && (rd != wr);
  endfunction

  task automatic model_apply(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'((a / 4) % NW);
    if (is_legal(rd, wr, a)) begin
      if (rd) ref_dout = ref_mem[idx];
      else    ref_mem[idx] = d;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    ref_dout = '0;
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.din       = d;
  endtask

  task automatic scramble();
    bus.mem_read  = 1'($urandom);
    bus.mem_write = 1'($urandom);
    bus.addr      = $urandom;
    bus.din       = $urandom;
  endtask

  // Called at the negedge after an acceptance edge has passed; returns at the
  // first negedge back in IDLE.
  task automatic wait_resp(input string tag, input bit exp_err);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid === 1'b1) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(n), 32'(LAT + 1));
    check({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, exp_err});
    check({tag, "_dout"}, bus.dout, ref_dout);
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'd0, bus.resp_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic do_req(input string tag, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    drive(rd, wr, a, d);
    @(posedge clk);
    model_apply(rd, wr, a, d);
    #1;
    bus.req_valid = 1'b0;
    scramble();
    wait_resp(tag, !is_legal(rd, wr, a));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int k;
    bit rdy;
    bit saw_resp;
    bit rd, wr;
    logic [31:0] a, d, a_a, a_b, d_a, d_b;

    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.din       = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_dout", bus.dout, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    do_req("load_0x40", 1'b1, 1'b0, 32'h40, 32'h0);

    do_req("store_0x10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_req("load_0x10", 1'b1, 1'b0, 32'h10, 32'h0);
    check("load_0x10_value", bus.dout, 32'hDEADBEEF);

    do_req("store_wrap", 1'b0, 1'b1, 32'h1004, 32'h12345678);
    do_req("load_wrap", 1'b1, 1'b0, 32'h4, 32'h0);
    check("load_wrap_value", bus.dout, 32'h12345678);

    do_req("ill_misaligned", 1'b1, 1'b0, 32'h13, 32'h0);
    do_req("ill_both", 1'b1, 1'b1, 32'h10, 32'h55555555);
    do_req("ill_neither", 1'b0, 1'b0, 32'h10, 32'hAAAAAAAA);
    check("ill_dout_kept", bus.dout, 32'h12345678);
    do_req("reload_0x10", 1'b1, 1'b0, 32'h10, 32'h0);
    check("reload_0x10_value", bus.dout, 32'hDEADBEEF);

    // Back-to-back: req_valid held high, second store presented during BUSY.
    a_a = 32'h100; d_a = $urandom;
    a_b = 32'h204; d_b = $urandom;
    drive(1'b0, 1'b1, a_a, d_a);
    @(posedge clk);
    model_apply(1'b0, 1'b1, a_a, d_a);
    #1;
    drive(1'b0, 1'b1, a_b, d_b);
    k = 0;
    rdy = 1'b0;
    while (k < 20 && !rdy) begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      k++;
    end
    model_apply(1'b0, 1'b1, a_b, d_b);
    #1;
    bus.req_valid = 1'b0;
    scramble();
    check("b2b_interval", 32'(k), 32'(LAT + 2));
    wait_resp("b2b_second", 1'b0);
    do_req("b2b_load_a", 1'b1, 1'b0, a_a, 32'h0);
    check("b2b_load_a_value", bus.dout, d_a);
    do_req("b2b_load_b", 1'b1, 1'b0, a_b, 32'h0);
    check("b2b_load_b_value", bus.dout, d_b);

    // Reset one cycle after acceptance aborts the store.
    drive(1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    saw_resp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) saw_resp = 1'b1;
    end
    check("abort_no_resp", {31'd0, saw_resp}, 32'd0);
    check("abort_dout", bus.dout, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    do_req("abort_load_0x20", 1'b1, 1'b0, 32'h20, 32'h0);
    check("abort_load_0x20_value", bus.dout, 32'd0);

    // Random traffic over a small set of words with random upper address bits.
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      rd = (kind == 0) || (kind >= 2 && kind <= 5);
      wr = (kind == 0) || (kind >= 6);
      a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      d  = $urandom;
      do_req($sformatf("rand%0d", i), rd, wr, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
